dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the core load/store path and a debug/loader port.
//  Sits between the core (ALU address, rs2 store data, mem read/write enables) and the data memory.
//  Grants one requester per cycle using round-robin with bounded bursts.
//  Routes the 1-cycle-latency read data back to the requester that issued the read.
// PARAMETERS
//  DATA_WIDTH       32  width of write/read data
//  DMEM_ADDR_WIDTH  10  word address width into data memory
//  MAX_BURST        4   max consecutive grants to one requester while the other waits (>=1)
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst_n           in   1     reset: asynchronous, active-low
//  core_req        in   1     core requests an access this cycle
//  core_we         in   1     1=store, 0=load
//  core_addr       in   DMEM_ADDR_WIDTH  core word address
//  core_wdata      in   DATA_WIDTH       core store data
//  core_gnt        out  1     core access accepted this cycle (comb.)
//  core_rvalid     out  1     core load data valid (cycle after granted load)
//  core_rdata      out  DATA_WIDTH       core load data, 0 when core_rvalid=0
//  dbg_req/dbg_we/dbg_addr/dbg_wdata  in  as core_*   debug port request
//  dbg_gnt/dbg_rvalid/dbg_rdata       out as core_*   debug port response
//  mem_read_en     out  1     to data memory
//  mem_write_en    out  1     to data memory
//  mem_addr        out  DMEM_ADDR_WIDTH  to data memory
//  mem_write_data  out  DATA_WIDTH       to data memory
//  mem_read_data   in   DATA_WIDTH       from data memory, valid 1 cycle after mem_read_en
// BEHAVIOUR
//  - State: owner FSM {IDLE, CORE_BURST, DBG_BURST}, burst_cnt (clog2(MAX_BURST+1) bits),
//    last_winner (1b), rd_pend_q, rd_owner_q. Reset: IDLE, burst_cnt=0, last_winner=DBG
//    (core wins first tie), rd_pend_q=0. All outputs 0 while rst_n=0.
//  - Winner (comb., same cycle): in X_BURST with X_req=1 and burst_cnt<MAX_BURST -> X;
//    else only one req -> it; both -> requester != last_winner; none -> no grant.
//  - X_gnt = winner==X. Transfer = req & gnt; exactly one gnt max per cycle; gnt never without req.
//  - Mem mux: winner's addr/wdata to mem_addr/mem_write_data; mem_write_en = transfer & we;
//    mem_read_en = transfer & ~we. No winner: enables 0, addr/wdata 0.
//  - Next state: winner==owner continuing -> burst_cnt+1; new winner -> X_BURST, burst_cnt=1;
//    no winner -> IDLE, burst_cnt=0. last_winner updates on every grant.
//  - Burst cap: at burst_cnt==MAX_BURST and other req=1, other wins next; if other idle,
//    owner keeps winning, burst_cnt saturates at MAX_BURST (no wrap).
//  - Worst-case wait for a steadily requesting port: MAX_BURST cycles.
//  - Read return: rd_pend_q<=mem_read_en, rd_owner_q<=winner. Next cycle rd_owner's
//    rvalid=1 and rdata=mem_read_data; other port rvalid=0, rdata=0.
//  - Back-to-back reads from alternating owners each return to their own issuer.
//  - Write then read same address on consecutive cycles: ordering = grant order; arbiter adds none.
//  - Reset mid-operation: pending rvalid dropped; no memory enables asserted during reset.
//  - Ungranted requester must hold req/we/addr/wdata stable until gnt.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs core_wait_cnt, dbg_wait_cnt (16b each); each
//    increments on cycles with X_req=1 & X_gnt=0, saturates at 16'hFFFF, reset to 0.
//  Undefined: ports and counters absent; arbitration identical.
// TESTING
//  1. Core only: load addr 0x005 -> core_gnt same cycle, mem_read_en=1, next cycle
//     core_rvalid=1 with mem data 0x1234_5678; dbg_rvalid=0.
//  2. Simultaneous first req after reset, both loads -> core wins cycle 0, dbg cycle 1,
//     rvalids return to correct port in cycles 1 and 2.
//  3. MAX_BURST=4, core_req held high, dbg_req raised at cycle 0 -> core gnt cycles 0-3,
//     dbg gnt cycle 4, dbg_wait_cnt=4 (STATS_EN).
//  4. Debug store 0xDEAD_BEEF @0x3FF alone for 10 cycles -> dbg_gnt every cycle,
//     burst_cnt saturates at 4, mem_write_en=1, addr=0x3FF, no wrap.
//  5. Core load granted, rst_n low next cycle -> core_rvalid stays 0, all outputs 0,
//     FSM IDLE; after release first tie goes to core.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single-port data memory between the core load/store path and a
//   debug/loader port. One requester is granted per cycle using round-robin
//   arbitration with bursts bounded to MAX_BURST consecutive grants while the
//   other side waits. 1-cycle-latency read data is routed back to the port
//   that issued the read.
//
// Parameters
//   DATA_WIDTH       width of write/read data
//   DMEM_ADDR_WIDTH  word address width into data memory
//   MAX_BURST        max consecutive grants to one requester while other waits
//
// Ports
//   clk, rst_n                       clock / asynchronous active-low reset
//   core_req/we/addr/wdata  (in)     core request
//   core_gnt/rvalid/rdata   (out)    core grant (comb.) and load response
//   dbg_req/we/addr/wdata   (in)     debug request
//   dbg_gnt/rvalid/rdata    (out)    debug grant (comb.) and load response
//   mem_read_en/write_en/addr/write_data (out)  data memory request
//   mem_read_data           (in)     data memory read data, 1 cycle latency
//
// Optional feature
//   DMEM_ARB_STATS_EN: adds core_wait_cnt / dbg_wait_cnt (16b saturating
//   counts of requested-but-not-granted cycles).
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DMEM_ADDR_WIDTH = 10,
    parameter int unsigned MAX_BURST       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       core_req,
    input  logic                       core_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]      core_wdata,
    output logic                       core_gnt,
    output logic                       core_rvalid,
    output logic [DATA_WIDTH-1:0]      core_rdata,
    input  logic                       dbg_req,
    input  logic                       dbg_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]      dbg_wdata,
    output logic                       dbg_gnt,
    output logic                       dbg_rvalid,
    output logic [DATA_WIDTH-1:0]      dbg_rdata,
    output logic                       mem_read_en,
    output logic                       mem_write_en,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_write_data,
    input  logic [DATA_WIDTH-1:0]      mem_read_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]                core_wait_cnt,
    output logic [15:0]                dbg_wait_cnt
`endif
);

    localparam int unsigned     CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CORE_BURST = 2'd1,
        DBG_BURST  = 2'd2
    } state_t;

    typedef enum logic {
        SEL_CORE = 1'b0,
        SEL_DBG  = 1'b1
    } sel_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;
    sel_t             r_last_winner;
    logic             r_rd_pend;
    sel_t             r_rd_owner;

    logic             w_win_valid;
    sel_t             w_win;
    logic             w_win_we;

    // Arbitration: burst owner keeps the port while under the cap, otherwise
    // plain round-robin. Gated by rst_n so nothing is granted during reset.
    always_comb begin
        w_win_valid = 1'b0;
        w_win       = SEL_CORE;
        if (!rst_n) begin
            w_win_valid = 1'b0;
        end else if (r_state == CORE_BURST && core_req && r_burst_cnt < CNT_MAX) begin
            w_win_valid = 1'b1;
            w_win       = SEL_CORE;
        end else if (r_state == DBG_BURST && dbg_req && r_burst_cnt < CNT_MAX) begin
            w_win_valid = 1'b1;
            w_win       = SEL_DBG;
        end else if (core_req && dbg_req) begin
            w_win_valid = 1'b1;
            w_win       = (r_last_winner == SEL_CORE) ? SEL_DBG : SEL_CORE;
        end else if (core_req) begin
            w_win_valid = 1'b1;
            w_win       = SEL_CORE;
        end else if (dbg_req) begin
            w_win_valid = 1'b1;
            w_win       = SEL_DBG;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_burst_cnt   <= '0;
            r_last_winner <= SEL_DBG;
            r_rd_pend     <= 1'b0;
            r_rd_owner    <= SEL_CORE;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            if (w_win_valid) begin
                r_last_winner <= w_win;
            end
            r_rd_pend  <= mem_read_en;
            r_rd_owner <= w_win;
        end
    end

    // Next-state: continuing owner counts up (saturating), a new owner
    // starts a fresh burst, no grant returns to IDLE.
    always_comb begin
        w_state_nxt     = IDLE;
        w_burst_cnt_nxt = '0;
        if (w_win_valid) begin
            if ((w_win == SEL_CORE && r_state == CORE_BURST) ||
                (w_win == SEL_DBG  && r_state == DBG_BURST)) begin
                w_state_nxt     = r_state;
                w_burst_cnt_nxt = (r_burst_cnt == CNT_MAX) ? CNT_MAX : r_burst_cnt + CNT_ONE;
            end else begin
                w_state_nxt     = (w_win == SEL_CORE) ? CORE_BURST : DBG_BURST;
                w_burst_cnt_nxt = CNT_ONE;
            end
        end
    end

    // Outputs: grants, memory mux, read-return routing
    always_comb begin
        core_gnt       = w_win_valid && (w_win == SEL_CORE);
        dbg_gnt        = w_win_valid && (w_win == SEL_DBG);
        w_win_we       = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (core_gnt) begin
            w_win_we       = core_we;
            mem_addr       = core_addr;
            mem_write_data = core_wdata;
        end else if (dbg_gnt) begin
            w_win_we       = dbg_we;
            mem_addr       = dbg_addr;
            mem_write_data = dbg_wdata;
        end
        mem_write_en = w_win_valid & w_win_we;
        mem_read_en  = w_win_valid & ~w_win_we;

        core_rvalid = r_rd_pend && (r_rd_owner == SEL_CORE);
        dbg_rvalid  = r_rd_pend && (r_rd_owner == SEL_DBG);
        core_rdata  = core_rvalid ? mem_read_data : '0;
        dbg_rdata   = dbg_rvalid  ? mem_read_data : '0;
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_wait_cnt <= '0;
            dbg_wait_cnt  <= '0;
        end else begin
            if (core_req && !core_gnt && core_wait_cnt != 16'hFFFF) begin
                core_wait_cnt <= core_wait_cnt + 16'd1;
            end
            if (dbg_req && !dbg_gnt && dbg_wait_cnt != 16'hFFFF) begin
                dbg_wait_cnt <= dbg_wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
